// File: rtl/data_bus_mmio_if.sv
// Memory-request bus between the datapath MEM stage and data_bus_mmio.
//   MemAddr   - byte address (bits [1:0] ignored)
//   WriteData - store data
//   MemRead   - load strobe
//   MemWrite  - store strobe
//   ReadData  - load data, combinational from the slave in the same cycle
interface data_bus_mmio_if;
    logic [31:0] MemAddr;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData;

    modport master (
        output MemAddr,
        output WriteData,
        output MemRead,
        output MemWrite,
        input  ReadData
    );

    modport slave (
        input  MemAddr,
        input  WriteData,
        input  MemRead,
        input  MemWrite,
        output ReadData
    );
endinterface

// File: rtl/data_bus_mmio.sv
// Memory-side bus block: decodes MEM-stage requests into a word-addressed
// async-read data RAM plus LED, switch and compare-timer registers.
//   clk, reset - single clock, synchronous active-high reset
//   bus        - request/response bus (slave side), zero-latency reads
//   sw         - asynchronous switch inputs (2-flop synchronized)
//   led        - LED register
//   timer_irq  - level interrupt, MATCH & IRQEN
//   bus_err    - sticky unmapped-access flag, cleared only by reset
module data_bus_mmio #(
    parameter int unsigned DMEM_WORDS = 256,
    parameter int unsigned LED_W      = 16,
    parameter int unsigned SW_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    data_bus_mmio_if.slave    bus,
    input  logic [SW_W-1:0]   sw,
    output logic [LED_W-1:0]  led,
    output logic              timer_irq,
    output logic              bus_err
);

    localparam int unsigned AW = $clog2(DMEM_WORDS);

    // Word addresses (byte address >> 2) of the peripheral registers
    localparam logic [29:0] LED_WA   = 30'h0000_2000;
    localparam logic [29:0] SW_WA    = 30'h0000_2001;
    localparam logic [29:0] TCNT_WA  = 30'h0000_2002;
    localparam logic [29:0] TCMP_WA  = 30'h0000_2003;
    localparam logic [29:0] TCTRL_WA = 30'h0000_2004;

    logic [31:0] mem [DMEM_WORDS];

    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_sync;

    logic [31:0] tcnt;
    logic [31:0] tcmp;
    logic        en;
    logic        autoreload;
    logic        match;
    logic        irqen;

    logic [LED_W-1:0] led_d;
    logic [31:0]      tcnt_d;
    logic [31:0]      tcmp_d;
    logic             en_d;
    logic             autoreload_d;
    logic             match_d;
    logic             irqen_d;
    logic             bus_err_d;
    logic             irq_d;

    logic [29:0]   wa;
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          led_hit;
    logic          sw_hit;
    logic          tcnt_hit;
    logic          tcmp_hit;
    logic          tctrl_hit;
    logic          mapped;
    logic          cmp_hit;

    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, bus.MemAddr[1:0]};

    // Address decode
    always_comb begin
        wa        = bus.MemAddr[31:2];
        ram_idx   = bus.MemAddr[AW+1:2];
        ram_hit   = (bus.MemAddr[31:AW+2] == '0);
        led_hit   = (wa == LED_WA);
        sw_hit    = (wa == SW_WA);
        tcnt_hit  = (wa == TCNT_WA);
        tcmp_hit  = (wa == TCMP_WA);
        tctrl_hit = (wa == TCTRL_WA);
        mapped    = ram_hit | led_hit | sw_hit | tcnt_hit | tcmp_hit | tctrl_hit;
    end

    // Zero-latency read mux; RAM read sees the pre-write contents
    always_comb begin
        bus.ReadData = 32'h0;
        if (bus.MemRead) begin
            if (ram_hit)        bus.ReadData = mem[ram_idx];
            else if (led_hit)   bus.ReadData = 32'(led);
            else if (sw_hit)    bus.ReadData = 32'(sw_sync);
            else if (tcnt_hit)  bus.ReadData = tcnt;
            else if (tcmp_hit)  bus.ReadData = tcmp;
            else if (tctrl_hit) bus.ReadData = {28'h0, irqen, match, autoreload, en};
        end
    end

    // Data RAM: no reset, so writes commit even while reset is asserted
    always_ff @(posedge clk) begin
        if (bus.MemWrite && ram_hit) begin
            mem[ram_idx] <= bus.WriteData;
        end
    end

    // Register next-state: bus writes, timer step, sticky error
    always_comb begin
        led_d        = led;
        tcnt_d       = tcnt;
        tcmp_d       = tcmp;
        en_d         = en;
        autoreload_d = autoreload;
        match_d      = match;
        irqen_d      = irqen;
        bus_err_d    = bus_err;
        cmp_hit      = en && (tcnt == tcmp);

        if (bus.MemWrite && led_hit)  led_d  = bus.WriteData[LED_W-1:0];
        if (bus.MemWrite && tcmp_hit) tcmp_d = bus.WriteData;
        if (bus.MemWrite && tctrl_hit) begin
            en_d         = bus.WriteData[0];
            autoreload_d = bus.WriteData[1];
            irqen_d      = bus.WriteData[3];
            if (bus.WriteData[2]) match_d = 1'b0;
        end

        // TCNT write beats the timer; a match set beats the W1C clear above
        if (bus.MemWrite && tcnt_hit) begin
            tcnt_d = bus.WriteData;
        end else if (cmp_hit) begin
            match_d = 1'b1;
            tcnt_d  = autoreload ? 32'h0 : 32'(tcnt + 32'd1);
        end else if (en) begin
            tcnt_d = 32'(tcnt + 32'd1);
        end

        if ((bus.MemRead || bus.MemWrite) && !mapped) bus_err_d = 1'b1;

        irq_d = match_d & irqen_d;
    end

    // State registers and 2-flop switch synchronizer
    always_ff @(posedge clk) begin
        if (reset) begin
            led        <= '0;
            tcnt       <= 32'h0;
            tcmp       <= 32'hFFFF_FFFF;
            en         <= 1'b0;
            autoreload <= 1'b0;
            match      <= 1'b0;
            irqen      <= 1'b0;
            bus_err    <= 1'b0;
            timer_irq  <= 1'b0;
            sw_meta    <= '0;
            sw_sync    <= '0;
        end else begin
            led        <= led_d;
            tcnt       <= tcnt_d;
            tcmp       <= tcmp_d;
            en         <= en_d;
            autoreload <= autoreload_d;
            match      <= match_d;
            irqen      <= irqen_d;
            bus_err    <= bus_err_d;
            timer_irq  <= irq_d;
            sw_meta    <= sw;
            sw_sync    <= sw_meta;
        end
    end

endmodule

// File: tb/tb_data_bus_mmio.sv
// Directed self-checking bench for data_bus_mmio.
module tb_data_bus_mmio;

    localparam logic [31:0] A_LED   = 32'h0000_8000;
    localparam logic [31:0] A_SW    = 32'h0000_8004;
    localparam logic [31:0] A_TCNT  = 32'h0000_8008;
    localparam logic [31:0] A_TCMP  = 32'h0000_800C;
    localparam logic [31:0] A_TCTRL = 32'h0000_8010;

    logic        clk;
    logic        reset;
    logic [15:0] sw;
    logic [15:0] led;
    logic        timer_irq;
    logic        bus_err;

    int n_tests;
    int n_fail;

    data_bus_mmio_if bus_if ();

    data_bus_mmio #(
        .DMEM_WORDS (256),
        .LED_W      (16),
        .SW_W       (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .sw        (sw),
        .led       (led),
        .timer_irq (timer_irq),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus_if.MemAddr   = addr;
        bus_if.WriteData = data;
        bus_if.MemWrite  = 1'b1;
        step();
        bus_if.MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus_if.MemAddr = addr;
        bus_if.MemRead = 1'b1;
        #1;
        data = bus_if.ReadData;
        bus_if.MemRead = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_tests++;
        if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led got %h exp 0000", led); end
        n_tests++;
        if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", timer_irq); end
        n_tests++;
        if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b exp 0", bus_err); end
        bus_if.MemAddr = A_TCMP;
        #1;
        n_tests++;
        if (bus_if.ReadData !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_idle got %h exp 0", bus_if.ReadData); end
        rd(A_TCMP, v);
        n_tests++;
        if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_tcmp got %h exp ffffffff", v); end
        rd(A_TCNT, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL reset_tcnt got %h exp 0", v); end
        rd(A_TCTRL, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL reset_tctrl got %h exp 0", v); end
    endtask

    task automatic test_ram();
        logic [31:0] v;
        wr(32'h10, 32'hDEAD_BEEF);
        wr(32'h3FC, 32'hCAFE_F00D);
        rd(32'h10, v);
        n_tests++;
        if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_0x10 got %h exp deadbeef", v); end
        rd(32'h3FC, v);
        n_tests++;
        if (v !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ram_0x3fc got %h exp cafef00d", v); end
        wr(32'h13, 32'h1111_2222);
        rd(32'h10, v);
        n_tests++;
        if (v !== 32'h1111_2222) begin n_fail++; $display("FAIL ram_lowbits got %h exp 11112222", v); end
        bus_if.MemAddr = 32'h10;
        #1;
        n_tests++;
        if (bus_if.ReadData !== 32'h0) begin n_fail++; $display("FAIL ram_noread got %h exp 0", bus_if.ReadData); end
    endtask

    task automatic test_led_sw();
        logic [31:0] v;
        wr(A_LED, 32'h0000_A5A5);
        n_tests++;
        if (led !== 16'hA5A5) begin n_fail++; $display("FAIL led_out got %h exp a5a5", led); end
        rd(A_LED, v);
        n_tests++;
        if (v !== 32'h0000_A5A5) begin n_fail++; $display("FAIL led_read got %h exp 0000a5a5", v); end
        sw = 16'h1234;
        rd(A_SW, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL sw_cycle0 got %h exp 0", v); end
        step();
        rd(A_SW, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL sw_cycle1 got %h exp 0", v); end
        step();
        rd(A_SW, v);
        n_tests++;
        if (v !== 32'h0000_1234) begin n_fail++; $display("FAIL sw_cycle2 got %h exp 00001234", v); end
    endtask

    task automatic test_timer_autoreload();
        logic [31:0] v;
        logic [31:0] exp_cnt [6];
        logic [31:0] exp_ctl [6];
        logic        exp_irq [6];
        exp_cnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        exp_ctl = '{32'hB, 32'hB, 32'hB, 32'hB, 32'hF, 32'hF};
        exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        wr(A_TCMP, 32'd3);
        wr(A_TCTRL, 32'hB);
        for (int i = 0; i < 6; i++) begin
            rd(A_TCNT, v);
            n_tests++;
            if (v !== exp_cnt[i]) begin n_fail++; $display("FAIL ar_tcnt[%0d] got %h exp %h", i, v, exp_cnt[i]); end
            rd(A_TCTRL, v);
            n_tests++;
            if (v !== exp_ctl[i]) begin n_fail++; $display("FAIL ar_tctrl[%0d] got %h exp %h", i, v, exp_ctl[i]); end
            n_tests++;
            if (timer_irq !== exp_irq[i]) begin n_fail++; $display("FAIL ar_irq[%0d] got %b exp %b", i, timer_irq, exp_irq[i]); end
            step();
        end
        // TCNT=2 here: clear only
        wr(A_TCTRL, 32'hF);
        rd(A_TCTRL, v);
        n_tests++;
        if (v !== 32'hB) begin n_fail++; $display("FAIL ar_clear_tctrl got %h exp 0000000b", v); end
        n_tests++;
        if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL ar_clear_irq got %b exp 0", timer_irq); end
        rd(A_TCNT, v);
        n_tests++;
        if (v !== 32'd3) begin n_fail++; $display("FAIL ar_clear_tcnt got %h exp 3", v); end
        // TCNT=3 here: clear collides with a new match, set wins
        wr(A_TCTRL, 32'hF);
        rd(A_TCTRL, v);
        n_tests++;
        if (v !== 32'hF) begin n_fail++; $display("FAIL ar_setwins_tctrl got %h exp 0000000f", v); end
        n_tests++;
        if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL ar_setwins_irq got %b exp 1", timer_irq); end
        wr(A_TCTRL, 32'h4);
        rd(A_TCTRL, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL ar_stop_tctrl got %h exp 0", v); end
        n_tests++;
        if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL ar_stop_irq got %b exp 0", timer_irq); end
    endtask

    task automatic test_timer_wrap();
        logic [31:0] v;
        logic [31:0] exp_cnt [10];
        logic [31:0] exp_ctl [10];
        exp_cnt = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2,
                    32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        exp_ctl = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1,
                    32'h1, 32'h1, 32'h1, 32'h5, 32'h5};
        wr(A_TCMP, 32'd5);
        wr(A_TCNT, 32'hFFFF_FFFE);
        wr(A_TCTRL, 32'h1);
        for (int i = 0; i < 10; i++) begin
            rd(A_TCNT, v);
            n_tests++;
            if (v !== exp_cnt[i]) begin n_fail++; $display("FAIL wrap_tcnt[%0d] got %h exp %h", i, v, exp_cnt[i]); end
            rd(A_TCTRL, v);
            n_tests++;
            if (v !== exp_ctl[i]) begin n_fail++; $display("FAIL wrap_tctrl[%0d] got %h exp %h", i, v, exp_ctl[i]); end
            n_tests++;
            if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL wrap_irq[%0d] got %b exp 0", i, timer_irq); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        // Timer still enabled: the written value must beat the increment
        wr(A_TCNT, 32'h100);
        rd(A_TCNT, v);
        n_tests++;
        if (v !== 32'h100) begin n_fail++; $display("FAIL tcnt_write_wins got %h exp 00000100", v); end
        step();
        rd(A_TCNT, v);
        n_tests++;
        if (v !== 32'h101) begin n_fail++; $display("FAIL tcnt_after_write got %h exp 00000101", v); end
        wr(A_TCTRL, 32'h4);
        rd(A_TCTRL, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL b2b_stop_tctrl got %h exp 0", v); end
        wr(32'h20, 32'h1);
        bus_if.MemAddr   = 32'h20;
        bus_if.WriteData = 32'h2;
        bus_if.MemRead   = 1'b1;
        bus_if.MemWrite  = 1'b1;
        #1;
        n_tests++;
        if (bus_if.ReadData !== 32'h1) begin n_fail++; $display("FAIL rw_same_cycle got %h exp 1", bus_if.ReadData); end
        step();
        bus_if.MemWrite = 1'b0;
        #1;
        n_tests++;
        if (bus_if.ReadData !== 32'h2) begin n_fail++; $display("FAIL rw_next_cycle got %h exp 2", bus_if.ReadData); end
        bus_if.MemRead = 1'b0;
    endtask

    task automatic test_unmapped();
        logic [31:0] v;
        wr(A_SW, 32'h0000_FFFF);
        n_tests++;
        if (bus_err !== 1'b0) begin n_fail++; $display("FAIL sw_write_no_err got %b exp 0", bus_err); end
        rd(A_SW, v);
        n_tests++;
        if (v !== 32'h0000_1234) begin n_fail++; $display("FAIL sw_write_ignored got %h exp 00001234", v); end
        rd(32'h0000_9000, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_rdata got %h exp 0", v); end
        bus_if.MemRead = 1'b1;
        step();
        bus_if.MemRead = 1'b0;
        n_tests++;
        if (bus_err !== 1'b1) begin n_fail++; $display("FAIL unmapped_err got %b exp 1", bus_err); end
        rd(32'h0000_0400, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL past_ram_rdata got %h exp 0", v); end
        step();
        step();
        n_tests++;
        if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", bus_err); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        wr(A_TCTRL, 32'h1);
        step();
        step();
        rd(A_TCNT, v);
        n_tests++;
        if (v === 32'h0 || v === 32'h101) begin n_fail++; $display("FAIL run_before_reset got %h exp counting", v); end
        reset = 1'b1;
        wr(A_LED, 32'h0000_FFFF);
        wr(32'h30, 32'h55);
        reset = 1'b0;
        n_tests++;
        if (led !== 16'h0) begin n_fail++; $display("FAIL rst_led got %h exp 0000", led); end
        n_tests++;
        if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_bus_err got %b exp 0", bus_err); end
        rd(A_TCNT, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL rst_tcnt got %h exp 0", v); end
        rd(A_TCMP, v);
        n_tests++;
        if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_tcmp got %h exp ffffffff", v); end
        rd(A_TCTRL, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL rst_tctrl got %h exp 0", v); end
        rd(32'h30, v);
        n_tests++;
        if (v !== 32'h55) begin n_fail++; $display("FAIL rst_ram_write got %h exp 55", v); end
        step();
        rd(A_TCNT, v);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL rst_tcnt_stopped got %h exp 0", v); end
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        reset            = 1'b1;
        sw               = 16'h0;
        bus_if.MemAddr   = 32'h0;
        bus_if.WriteData = 32'h0;
        bus_if.MemRead   = 1'b0;
        bus_if.MemWrite  = 1'b0;
        test_reset();
        test_ram();
        test_led_sw();
        test_timer_autoreload();
        test_timer_wrap();
        test_back_to_back();
        test_unmapped();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
